// File: rtl/serial_alu_pkg.sv
// Shared op codes, FSM encoding and op helpers for the bit-serial ALU sequencer.
package serial_alu_pkg;

    localparam logic [3:0] OP_ZERO  = 4'b0000;
    localparam logic [3:0] OP_A     = 4'b0001;
    localparam logic [3:0] OP_NOT_A = 4'b1001;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_ADD   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Unknown codes collapse to ZERO so the datapath only ever sees legal ops.
    function automatic logic [3:0] legal_op(input logic [3:0] op);
        case (op)
            OP_A, OP_NOT_A, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: return op;
            default: return OP_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/one_bit_alu.sv
// Single-bit combinational ALU slice; SUB computes b + ~a + carry_in.
// Purely combinational, no state and no backpressure.
module one_bit_alu
    import serial_alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carry_in_i,
    input  logic [3:0] f_i,
    output logic       result_o,
    output logic       carry_bit_o
);

    logic na;
    assign na = ~a_i;

    always_comb begin
        result_o    = 1'b0;
        carry_bit_o = 1'b0;
        case (f_i)
            OP_A:     result_o = a_i;
            OP_NOT_A: result_o = na;
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_ADD: begin
                result_o    = a_i ^ b_i ^ carry_in_i;
                carry_bit_o = (a_i & b_i) | (a_i & carry_in_i) | (b_i & carry_in_i);
            end
            OP_SUB: begin
                result_o    = na ^ b_i ^ carry_in_i;
                carry_bit_o = (na & b_i) | (na & carry_in_i) | (b_i & carry_in_i);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer running one_bit_alu over WIDTH-bit operands, LSB first.
// Latency WIDTH+1 cycles start->done; start_i ignored (not queued) while busy.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [3:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             alu_res, alu_carry;
    logic             last_bit;
    logic [3:0]       op_in;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign op_in    = legal_op(op_i);

    one_bit_alu u_alu (
        .a_i         (a_sh[0]),
        .b_i         (b_sh[0]),
        .carry_in_i  (carry_q),
        .f_i         (op_q),
        .result_o    (alu_res),
        .carry_bit_o (alu_carry)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_q     <= OP_ZERO;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_o <= '0;
            carry_o  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        a_sh    <= a_i;
                        b_sh    <= b_i;
                        op_q    <= op_in;
                        res_sh  <= '0;
                        cnt_q   <= '0;
                        // SUB is B + ~A + 1, so the +1 rides in on the carry.
                        carry_q <= (op_in == OP_SUB);
                    end
                end
                ST_SHIFT: begin
                    res_sh  <= {alu_res, res_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= is_arith(op_q) & alu_carry;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        result_o <= {alu_res, res_sh[WIDTH-1:1]};
                        carry_o  <= is_arith(op_q) & alu_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus directed literal expectations.
module tb_serial_alu_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       op = 4'b0000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, carry;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .result_o(result),
        .carry_o (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {carry, result} straight from the op definitions.
    function automatic logic [WIDTH:0] model_op(input logic [3:0] f, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        case (f)
            4'b0001: s = {1'b0, x};
            4'b1001: s = {1'b0, ~x};
            4'b0100: s = {1'b0, x & y};
            4'b0101: s = {1'b0, x | y};
            4'b0110: s = {1'b0, x ^ y};
            4'b0111: s = {1'b0, x} + {1'b0, y};
            4'b1111: s = {(y >= x), y - x};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Model: remaining cycles until idle; done is the last busy cycle.
    int               m_left = 0;
    logic [WIDTH-1:0] m_res = '0;
    logic             m_car = 1'b0;
    logic [WIDTH:0]   m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= '0;
            m_car  <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend <= model_op(op, a, b);
                m_left <= WIDTH + 1;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_res <= m_pend[WIDTH-1:0];
                m_car <= m_pend[WIDTH];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_left == 1));
            check("result", 32'(result), 32'(m_res));
            check("carry", 32'(carry), 32'(m_car));
        end
    end

    task automatic run_op(input string name, input logic [3:0] f, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp_res,
                          input logic exp_car);
        int lat;
        @(negedge clk);
        start = 1'b1; op = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 3 * WIDTH) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, 3 * WIDTH);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(WIDTH));
            check({name, "_res"}, 32'(result), 32'(exp_res));
            check({name, "_car"}, 32'(carry), 32'(exp_car));
        end
        @(negedge clk);
    endtask

    typedef struct {
        string            name;
        logic [3:0]       f;
        logic [WIDTH-1:0] x, y, r;
        logic             c;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int dcount;
        int dpos[2];

        vecs[0] = '{"add_5a_3c", 4'b0111, 8'h5A, 8'h3C, 8'h96, 1'b0};
        vecs[1] = '{"add_ff_01", 4'b0111, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{"sub_05_0c", 4'b1111, 8'h05, 8'h0C, 8'h07, 1'b1};
        vecs[3] = '{"sub_0c_05", 4'b1111, 8'h0C, 8'h05, 8'hF9, 1'b0};
        vecs[4] = '{"xor",       4'b0110, 8'hA5, 8'h0F, 8'hAA, 1'b0};
        vecs[5] = '{"not_a",     4'b1001, 8'h0F, 8'h33, 8'hF0, 1'b0};
        vecs[6] = '{"and",       4'b0100, 8'hA5, 8'h0F, 8'h05, 1'b0};
        vecs[7] = '{"or",        4'b0101, 8'hA5, 8'h0F, 8'hAF, 1'b0};
        vecs[8] = '{"bad_op",    4'b0011, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[9] = '{"pass_a",    4'b0001, 8'h3C, 8'hC3, 8'h3C, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].c);

        // start held high; operands change mid-op and must not leak into the first op
        @(negedge clk);
        start = 1'b1; op = 4'b0111; a = 8'h11; b = 8'h22;
        dcount = 0;
        dpos[0] = -1; dpos[1] = -1;
        for (int j = 0; j < 2 * (WIDTH + 2); j++) begin
            @(negedge clk);
            if (j == 3) begin a = 8'h40; b = 8'h01; end
            if (done) begin
                if (dcount < 2) dpos[dcount] = j;
                if (dcount == 0) check("held_first_res", 32'(result), 32'h33);
                if (dcount == 1) check("held_second_res", 32'(result), 32'h41);
                dcount++;
            end
            if (j == 2 * (WIDTH + 2) - 1) start = 1'b0;
        end
        check("held_done_count", 32'(dcount), 32'd2);
        check("held_done_pos0", 32'(dpos[0]), 32'(WIDTH));
        check("held_done_pos1", 32'(dpos[1]), 32'(2 * WIDTH + 2));

        // reset during the third SHIFT cycle
        @(negedge clk);
        start = 1'b1; op = 4'b0111; a = 8'h77; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_carry", 32'(carry), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        run_op("after_rst_add", 4'b0111, 8'h01, 8'h01, 8'h02, 1'b0);

        // idle stability
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("idle_result", 32'(result), 32'h02);
            check("idle_carry", 32'(carry), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
